// File: rtl/washer_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : washer_timer_pkg
// Purpose  : Shared types and constants for the washer phase timer: timer
//            state encoding, one-shot/periodic mode values, default widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package washer_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } timer_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEFAULT_FREQ_W   = 8;
  localparam int DEFAULT_PERIOD_W = 8;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divides clk by a runtime frequency value and emits a one-cycle
//            sec_tick on the edge where the count wraps from freq-1 to 0.
// Ports    : clk      - system clock
//            reset    - synchronous active-high reset
//            clr      - force the count to 0 (wins over hold)
//            hold     - freeze the count; sec_tick is suppressed
//            freq     - clock ticks per second
//            sec_tick - high in the cycle whose edge wraps the count
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int FREQ_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              hold,
  input  logic [FREQ_W-1:0] freq,
  output logic              sec_tick
);

  logic [FREQ_W-1:0] count_q;
  logic [FREQ_W-1:0] count_d;
  logic              at_top;

  assign at_top = (count_q == (freq - FREQ_W'(1)));

  // Deliberately not qualified by clr: the owner derives clr from sec_tick
  // (expiry clears the count), so gating here would close a loop.
  assign sec_tick = !hold && at_top;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = at_top ? '0 : count_q + FREQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Purpose  : Second-resolution countdown timer for washer phase sequencing.
//            start/retrigger, pause/resume, abort, one-shot or auto-reload,
//            visible remaining seconds and a one-cycle done pulse.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            start               - latch config and (re)start counting
//            pause               - level; hold counters while high
//            abort               - return to idle without done
//            periodic            - mode sampled with start (1 = auto-reload)
//            clk_freq            - ticks per second, sampled with start
//            timer_period        - seconds, sampled with start
//            busy, paused        - state is RUN/PAUSED, state is PAUSED
//            remaining           - seconds left in the current period
//            done                - one-cycle pulse at period expiry
// Revision : 1.0 - initial release
// ============================================================================
module cycle_timer
  import washer_timer_pkg::*;
#(
  parameter int FREQ_W   = DEFAULT_FREQ_W,
  parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                abort,
  input  logic                periodic,
  input  logic [FREQ_W-1:0]   clk_freq,
  input  logic [PERIOD_W-1:0] timer_period,
  output logic                busy,
  output logic                paused,
  output logic [PERIOD_W-1:0] remaining,
  output logic                done
);

  timer_state_e        state_q, state_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                mode_q, mode_d;
  logic [PERIOD_W-1:0] remaining_q, remaining_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                paused_q, paused_d;

  logic                count_en;
  logic                presc_clr;
  logic                sec_tick;

  // Counting happens on any edge where the timer is active and not held.
  // The resume edge (PAUSED with pause low) counts, so a pause costs exactly
  // the number of edges on which pause was sampled high.
  assign count_en = !abort && !start && !pause && (state_q != ST_IDLE);

  tick_prescaler #(
    .FREQ_W (FREQ_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (presc_clr),
    .hold     (!count_en),
    .freq     (freq_q),
    .sec_tick (sec_tick)
  );

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    period_d    = period_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    presc_clr   = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      presc_clr   = 1'b1;
    end else if (start) begin
      freq_d    = clk_freq;
      period_d  = timer_period;
      mode_d    = periodic;
      presc_clr = 1'b1;
      // A zero rate or zero length has nothing to count: report done at once.
      if ((clk_freq == '0) || (timer_period == '0)) begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        done_d      = 1'b1;
      end else begin
        state_d     = ST_RUN;
        remaining_d = timer_period;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          presc_clr = 1'b1;
        end
      endcase

      if (count_en && sec_tick) begin
        if (remaining_q <= PERIOD_W'(1)) begin
          done_d = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            // Prescaler wraps to 0 on this same tick, so the reload
            // starts a fresh period with no gap cycle.
            remaining_d = period_q;
          end else begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            presc_clr   = 1'b1;
          end
        end else begin
          remaining_d = remaining_q - PERIOD_W'(1);
        end
      end
    end

    busy_d   = (state_d != ST_IDLE);
    paused_d = (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      freq_q      <= '0;
      period_q    <= '0;
      mode_q      <= MODE_ONESHOT;
      remaining_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
    end
  end

  assign busy      = busy_q;
  assign paused    = paused_q;
  assign remaining = remaining_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cycle_timer
// Purpose  : Directed self-checking bench for cycle_timer.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cycle_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       periodic = 1'b0;
  logic [7:0] clk_freq = 8'd0;
  logic [7:0] timer_period = 8'd0;
  logic       busy;
  logic       paused;
  logic [7:0] remaining;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cycle_timer #(
    .FREQ_W   (8),
    .PERIOD_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .periodic     (periodic),
    .clk_freq     (clk_freq),
    .timer_period (timer_period),
    .busy         (busy),
    .paused       (paused),
    .remaining    (remaining),
    .done         (done)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply start for one edge (E0); returns just after E0.
  task automatic arm(input int f, input int p, input logic per);
    clk_freq     = 8'(f);
    timer_period = 8'(p);
    periodic     = per;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    if (busy !== 1'b0) begin $display("FAIL reset busy: got %b expected 0", busy); n_fail++; end
    n_checks++;
    if (paused !== 1'b0) begin $display("FAIL reset paused: got %b expected 0", paused); n_fail++; end
    n_checks++;
    if (remaining !== 8'd0) begin $display("FAIL reset remaining: got %0d expected 0", remaining); n_fail++; end
    n_checks++;
    if (done !== 1'b0) begin $display("FAIL reset done: got %b expected 0", done); n_fail++; end
    n_checks++;
  endtask

  task automatic test_oneshot();
    int exp_rem[7] = '{3, 3, 2, 2, 1, 1, 0};
    arm(2, 3, 1'b0);
    for (int k = 0; k < 7; k++) begin
      if (remaining !== 8'(exp_rem[k])) begin
        $display("FAIL oneshot remaining k=%0d: got %0d expected %0d", k, remaining, exp_rem[k]); n_fail++;
      end
      n_checks++;
      if (done !== (k == 6)) begin
        $display("FAIL oneshot done k=%0d: got %b expected %b", k, done, (k == 6)); n_fail++;
      end
      n_checks++;
      if (busy !== (k < 6)) begin
        $display("FAIL oneshot busy k=%0d: got %b expected %b", k, busy, (k < 6)); n_fail++;
      end
      n_checks++;
      step();
    end
    if (done !== 1'b0) begin $display("FAIL oneshot done after: got %b expected 0", done); n_fail++; end
    n_checks++;
  endtask

  task automatic test_periodic();
    logic [7:0] er;
    logic       ed;
    arm(2, 3, 1'b1);
    for (int k = 0; k < 20; k++) begin
      er = 8'(3 - (k % 6) / 2);
      ed = (k > 0) && (k % 6 == 0);
      if (remaining !== er) begin
        $display("FAIL periodic remaining k=%0d: got %0d expected %0d", k, remaining, er); n_fail++;
      end
      n_checks++;
      if (done !== ed) begin
        $display("FAIL periodic done k=%0d: got %b expected %b", k, done, ed); n_fail++;
      end
      n_checks++;
      if (k == 19) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    if (busy !== 1'b0) begin $display("FAIL periodic abort busy: got %b expected 0", busy); n_fail++; end
    n_checks++;
    if (remaining !== 8'd0) begin $display("FAIL periodic abort remaining: got %0d expected 0", remaining); n_fail++; end
    n_checks++;
    for (int k = 0; k < 8; k++) begin
      if (done !== 1'b0) begin
        $display("FAIL periodic post-abort done k=%0d: got %b expected 0", k, done); n_fail++;
      end
      n_checks++;
      step();
    end
  endtask

  task automatic test_pause();
    int lost;
    int c;
    logic [7:0] er;
    arm(4, 2, 1'b0);
    for (int k = 0; k < 15; k++) begin
      lost = (k < 3) ? 0 : ((k > 7) ? 5 : k - 2);
      c    = k - lost;
      er   = (k >= 13) ? 8'd0 : 8'(2 - c / 4);
      if (remaining !== er) begin
        $display("FAIL pause remaining k=%0d: got %0d expected %0d", k, remaining, er); n_fail++;
      end
      n_checks++;
      if (paused !== (k >= 3 && k <= 7)) begin
        $display("FAIL pause paused k=%0d: got %b expected %b", k, paused, (k >= 3 && k <= 7)); n_fail++;
      end
      n_checks++;
      if (done !== (k == 13)) begin
        $display("FAIL pause done k=%0d: got %b expected %b", k, done, (k == 13)); n_fail++;
      end
      n_checks++;
      if (k == 2) pause = 1'b1;
      if (k == 7) pause = 1'b0;
      step();
    end
    if (busy !== 1'b0) begin $display("FAIL pause busy after: got %b expected 0", busy); n_fail++; end
    n_checks++;
  endtask

  task automatic test_zero();
    for (int pass = 0; pass < 2; pass++) begin
      arm((pass == 0) ? 3 : 0, (pass == 0) ? 0 : 4, 1'b0);
      if (done !== 1'b1) begin $display("FAIL zero done pass=%0d: got %b expected 1", pass, done); n_fail++; end
      n_checks++;
      if (busy !== 1'b0) begin $display("FAIL zero busy pass=%0d: got %b expected 0", pass, busy); n_fail++; end
      n_checks++;
      if (remaining !== 8'd0) begin
        $display("FAIL zero remaining pass=%0d: got %0d expected 0", pass, remaining); n_fail++;
      end
      n_checks++;
      step();
      if (done !== 1'b0) begin $display("FAIL zero done next pass=%0d: got %b expected 0", pass, done); n_fail++; end
      n_checks++;
      if (busy !== 1'b0) begin $display("FAIL zero busy next pass=%0d: got %b expected 0", pass, busy); n_fail++; end
      n_checks++;
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] er;
    arm(2, 5, 1'b0);
    for (int k = 0; k < 19; k++) begin
      if (k < 7)       er = 8'(5 - k / 2);
      else if (k >= 17) er = 8'd0;
      else             er = 8'(5 - (k - 7) / 2);
      if (remaining !== er) begin
        $display("FAIL retrigger remaining k=%0d: got %0d expected %0d", k, remaining, er); n_fail++;
      end
      n_checks++;
      if (done !== (k == 17)) begin
        $display("FAIL retrigger done k=%0d: got %b expected %b", k, done, (k == 17)); n_fail++;
      end
      n_checks++;
      if (k == 6) start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    arm(2, 5, 1'b0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    if (busy !== 1'b0) begin $display("FAIL midreset busy: got %b expected 0", busy); n_fail++; end
    n_checks++;
    if (paused !== 1'b0) begin $display("FAIL midreset paused: got %b expected 0", paused); n_fail++; end
    n_checks++;
    if (remaining !== 8'd0) begin $display("FAIL midreset remaining: got %0d expected 0", remaining); n_fail++; end
    n_checks++;
    for (int k = 0; k < 12; k++) begin
      if (done !== 1'b0) begin $display("FAIL midreset done k=%0d: got %b expected 0", k, done); n_fail++; end
      n_checks++;
      step();
    end
  endtask

  task automatic test_collisions();
    // abort on the expiry edge
    arm(1, 2, 1'b0);
    if (remaining !== 8'd2) begin $display("FAIL coll abort rem0: got %0d expected 2", remaining); n_fail++; end
    n_checks++;
    step();
    if (remaining !== 8'd1) begin $display("FAIL coll abort rem1: got %0d expected 1", remaining); n_fail++; end
    n_checks++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    if (done !== 1'b0) begin $display("FAIL coll abort done: got %b expected 0", done); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL coll abort busy: got %b expected 0", busy); n_fail++; end
    n_checks++;
    if (remaining !== 8'd0) begin $display("FAIL coll abort remaining: got %0d expected 0", remaining); n_fail++; end
    n_checks++;
    step();
    if (done !== 1'b0) begin $display("FAIL coll abort done later: got %b expected 0", done); n_fail++; end
    n_checks++;

    // start on the expiry edge
    arm(1, 2, 1'b0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    if (done !== 1'b0) begin $display("FAIL coll start done: got %b expected 0", done); n_fail++; end
    n_checks++;
    if (remaining !== 8'd2) begin $display("FAIL coll start remaining: got %0d expected 2", remaining); n_fail++; end
    n_checks++;
    if (busy !== 1'b1) begin $display("FAIL coll start busy: got %b expected 1", busy); n_fail++; end
    n_checks++;
    step();
    if (remaining !== 8'd1) begin $display("FAIL coll start rem1: got %0d expected 1", remaining); n_fail++; end
    n_checks++;
    step();
    if (done !== 1'b1) begin $display("FAIL coll start expiry done: got %b expected 1", done); n_fail++; end
    n_checks++;
    if (remaining !== 8'd0) begin $display("FAIL coll start expiry rem: got %0d expected 0", remaining); n_fail++; end
    n_checks++;
    step();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_zero();
    test_retrigger();
    test_reset_mid();
    test_collisions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
